// File: rtl/i2c_monitor.sv
// i2c_monitor: passive I2C bus monitor that filters SCL/SDA, reports START/STOP
// conditions and decodes each address/data byte with its ACK bit.
module i2c_monitor #(
  parameter int SYNC_STAGES    = 2,
  parameter int FILT_LEN       = 3,
  parameter int ADDR_FILTER_EN = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl,
  input  logic       sda,
  input  logic       detect_only,
  input  logic [6:0] match_addr,
  output logic [7:0] data_out,
  output logic       is_addr,
  output logic       rw,
  output logic       ack,
  output logic       addr_match,
  output logic       valid,
  output logic       detected,
  output logic       start_pulse,
  output logic       stop_pulse,
  output logic       busy,
  output logic       frame_err
);
  typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK} state_t;
  localparam logic [3:0] FILT_LAST = 4'(FILT_LEN - 1);
  state_t r_state, w_next;
  logic [SYNC_STAGES-1:0] r_scl_sync, r_sda_sync;
  logic [1:0] w_sync, r_filt, r_filt_d;
  logic [3:0] r_fcnt [2];
  logic [3:0] r_bit_cnt;
  logic [7:0] r_shift;
  logic r_hi_bit;
  logic w_scl, w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;
  logic w_bit_smp, w_ack_smp, w_det, w_valid, w_frame;
  assign w_sync = {r_scl_sync[SYNC_STAGES-1], r_sda_sync[SYNC_STAGES-1]};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_filt     <= '1;
      r_filt_d   <= '1;
      for (int k = 0; k < 2; k++) r_fcnt[k] <= '0;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda};
      r_filt_d   <= r_filt;
      for (int k = 0; k < 2; k++) begin
        if (w_sync[k] == r_filt[k]) r_fcnt[k] <= '0;
        else if (r_fcnt[k] == FILT_LAST) begin
          r_filt[k] <= w_sync[k];
          r_fcnt[k] <= '0;
        end else r_fcnt[k] <= r_fcnt[k] + 4'd1;
      end
    end
  end
  assign w_scl      = r_filt[1];
  assign w_sda      = r_filt[0];
  assign w_scl_rise = w_scl & ~r_filt_d[1];
  assign w_scl_fall = ~w_scl & r_filt_d[1];
  assign w_start    = w_scl & r_filt_d[1] & r_filt_d[0] & ~w_sda;
  assign w_stop     = w_scl & r_filt_d[1] & ~r_filt_d[0] & w_sda;
  assign w_bit_smp  = w_scl_rise & (r_state == ADDR || r_state == DATA);
  assign w_ack_smp  = w_scl_rise & (r_state == ADDR_ACK || r_state == DATA_ACK);
  assign w_det      = w_ack_smp & (r_state == ADDR_ACK || ADDR_FILTER_EN == 0 || addr_match);
  assign w_valid    = w_det & ~detect_only;
  // A bit sampled in the same SCL-high phase as START/STOP is the condition's own clock, not data
  assign w_frame    = (w_start | w_stop) & (r_bit_cnt != {3'b000, r_hi_bit});
  always_comb begin
    w_next = r_state;
    if (w_stop) w_next = IDLE;
    else if (w_start) w_next = ADDR;
    else if (w_bit_smp && r_bit_cnt == 4'd7) w_next = (r_state == ADDR) ? ADDR_ACK : DATA_ACK;
    else if (w_ack_smp) w_next = DATA;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_bit_cnt   <= '0;
      r_hi_bit    <= 1'b0;
      r_shift     <= '0;
      data_out    <= '0;
      is_addr     <= 1'b0;
      rw          <= 1'b0;
      ack         <= 1'b0;
      addr_match  <= 1'b0;
      valid       <= 1'b0;
      detected    <= 1'b0;
      start_pulse <= 1'b0;
      stop_pulse  <= 1'b0;
      busy        <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      r_state     <= w_next;
      start_pulse <= w_start;
      stop_pulse  <= w_stop;
      frame_err   <= w_frame;
      detected    <= w_det;
      valid       <= w_valid;
      busy        <= w_start ? 1'b1 : w_stop ? 1'b0 : busy;
      if (w_start | w_stop) r_bit_cnt <= '0;
      else if (w_bit_smp) r_bit_cnt <= r_bit_cnt + 4'd1;
      else if (w_ack_smp) r_bit_cnt <= '0;
      if (w_start | w_stop | w_scl_fall) r_hi_bit <= 1'b0;
      else if (w_bit_smp) r_hi_bit <= 1'b1;
      if (w_bit_smp) r_shift <= {r_shift[6:0], w_sda};
      if (w_start) addr_match <= 1'b0;
      else if (w_ack_smp && r_state == ADDR_ACK) addr_match <= (r_shift[7:1] == match_addr);
      if (w_valid) begin
        data_out <= r_shift;
        ack      <= ~w_sda;
        is_addr  <= (r_state == ADDR_ACK);
        if (r_state == ADDR_ACK) rw <= r_shift[0];
      end
    end
  end
endmodule

// File: tb/tb_i2c_monitor.sv
// tb_i2c_monitor: directed bus frames against two monitors (address filter on/off)
// with hand-computed expected bytes, flags, pulse counts and latency.
module tb_i2c_monitor;
  logic clk = 0, rst_n = 0, scl = 1, sda = 1, detect_only = 0;
  logic [6:0] match_addr = 7'h50;
  logic [7:0] data_out, nf_data_out;
  logic is_addr, rw, ack, addr_match, valid, detected, start_pulse, stop_pulse, busy, frame_err;
  logic nf_is_addr, nf_rw, nf_ack, nf_addr_match, nf_valid, nf_detected;
  logic nf_start_pulse, nf_stop_pulse, nf_busy, nf_frame_err;
  localparam int H = 8;
  always #5 clk = ~clk;
  i2c_monitor #(.SYNC_STAGES(2), .FILT_LEN(3), .ADDR_FILTER_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .scl(scl), .sda(sda), .detect_only(detect_only),
    .match_addr(match_addr), .data_out(data_out), .is_addr(is_addr), .rw(rw), .ack(ack),
    .addr_match(addr_match), .valid(valid), .detected(detected), .start_pulse(start_pulse),
    .stop_pulse(stop_pulse), .busy(busy), .frame_err(frame_err));
  i2c_monitor #(.SYNC_STAGES(2), .FILT_LEN(3), .ADDR_FILTER_EN(0)) dut_nf (
    .clk(clk), .rst_n(rst_n), .scl(scl), .sda(sda), .detect_only(detect_only),
    .match_addr(match_addr), .data_out(nf_data_out), .is_addr(nf_is_addr), .rw(nf_rw),
    .ack(nf_ack), .addr_match(nf_addr_match), .valid(nf_valid), .detected(nf_detected),
    .start_pulse(nf_start_pulse), .stop_pulse(nf_stop_pulse), .busy(nf_busy),
    .frame_err(nf_frame_err));
  int n_cmp = 0, n_err = 0;
  int n_valid = 0, n_det = 0, n_start = 0, n_stop = 0, n_ferr = 0, n_sf = 0, n_det_nf = 0;
  int b_v, b_d, b_s, b_p, b_f, b_sf, b_n, lat;
  logic [7:0] cap_data [64];
  logic cap_isaddr [64], cap_rw [64], cap_ack [64], cap_match [64];
  always @(negedge clk) begin
    if (valid && n_valid < 64) begin
      cap_data[n_valid]   <= data_out;
      cap_isaddr[n_valid] <= is_addr;
      cap_rw[n_valid]     <= rw;
      cap_ack[n_valid]    <= ack;
      cap_match[n_valid]  <= addr_match;
    end
    n_valid  <= n_valid + int'(valid);
    n_det    <= n_det + int'(detected);
    n_start  <= n_start + int'(start_pulse);
    n_stop   <= n_stop + int'(stop_pulse);
    n_ferr   <= n_ferr + int'(frame_err);
    n_sf     <= n_sf + int'(start_pulse & frame_err);
    n_det_nf <= n_det_nf + int'(nf_detected);
  end
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic snap();
    b_v = n_valid; b_d = n_det; b_s = n_start; b_p = n_stop;
    b_f = n_ferr; b_sf = n_sf; b_n = n_det_nf;
  endtask
  task automatic bus_start();
    sda = 0; tick(H);
    scl = 0; tick(H);
  endtask
  task automatic bus_stop();
    sda = 0; tick(H);
    scl = 1; tick(H);
    sda = 1; tick(H);
  endtask
  task automatic rep_start();
    sda = 1; tick(H);
    scl = 1; tick(H);
    sda = 0; tick(H);
    scl = 0; tick(H);
  endtask
  task automatic send_bit(logic b);
    sda = b; tick(H);
    scl = 1; tick(H);
    scl = 0; tick(H);
  endtask
  task automatic send_byte(logic [7:0] v, logic a);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
    send_bit(~a);
  endtask
  task automatic frame_a0_3c();
    bus_start();
    send_byte(8'hA0, 1'b1);
    send_byte(8'h3C, 1'b1);
    bus_stop();
    tick(H);
  endtask
  initial begin
    tick(3);
    check("rst_data", data_out, 0);
    check("rst_flags", {is_addr, rw, ack, addr_match, valid, detected, start_pulse, stop_pulse, busy, frame_err}, 0);
    rst_n = 1; tick(2);
    snap();
    bus_start();
    check("t1_busy_set", busy, 1);
    send_byte(8'hA0, 1'b1);
    send_byte(8'h3C, 1'b1);
    bus_stop(); tick(H);
    check("t1_nvalid", n_valid - b_v, 2);
    check("t1_addr_byte", cap_data[b_v], 8'hA0);
    check("t1_addr_flags", {cap_isaddr[b_v], cap_rw[b_v], cap_match[b_v], cap_ack[b_v]}, 4'b1011);
    check("t1_data_byte", cap_data[b_v+1], 8'h3C);
    check("t1_data_flags", {cap_isaddr[b_v+1], cap_ack[b_v+1]}, 2'b01);
    check("t1_pulses", {n_start - b_s, n_stop - b_p, n_ferr - b_f}, {32'd1, 32'd1, 32'd0});
    check("t1_busy_clr", busy, 0);
    rst_n = 0; tick(2); rst_n = 1; tick(2);
    detect_only = 1;
    snap();
    frame_a0_3c();
    check("t2_ndet", n_det - b_d, 2);
    check("t2_nvalid", n_valid - b_v, 0);
    check("t2_data_hold", data_out, 8'h00);
    detect_only = 0;
    snap();
    bus_start();
    send_byte(8'hA2, 1'b1);
    send_byte(8'hFF, 1'b0);
    bus_stop(); tick(H);
    check("t3_nvalid", n_valid - b_v, 1);
    check("t3_addr_byte", cap_data[b_v], 8'hA2);
    check("t3_nomatch", {cap_match[b_v], addr_match}, 2'b00);
    check("t3_ndet_filt", n_det - b_d, 1);
    check("t3_ndet_nofilt", n_det_nf - b_n, 2);
    snap();
    bus_start();
    send_byte(8'hA0, 1'b1);
    send_bit(1); send_bit(0); send_bit(1);
    rep_start();
    check("t4_busy_held", busy, 1);
    send_byte(8'hA1, 1'b1);
    bus_stop(); tick(H);
    check("t4_ferr_with_start", n_sf - b_sf, 1);
    check("t4_nferr", n_ferr - b_f, 1);
    check("t4_nstart", n_start - b_s, 2);
    check("t4_nvalid", n_valid - b_v, 2);
    check("t4_sr_byte", cap_data[b_v+1], 8'hA1);
    check("t4_sr_flags", {cap_isaddr[b_v+1], cap_rw[b_v+1]}, 2'b11);
    snap();
    sda = 0; tick(1); sda = 1; tick(20);
    check("t5_glitch_start", n_start - b_s, 0);
    check("t5_glitch_busy", busy, 0);
    sda = 0; lat = 0;
    for (int i = 1; i <= 20; i++) begin
      tick(1);
      if (start_pulse) begin
        lat = i;
        break;
      end
    end
    check("t5_latency", lat, 2 + 3 + 1);
    sda = 1; tick(H);
    check("t5_stop", {busy, 31'(n_ferr - b_f)}, 0);
    bus_start();
    send_byte(8'hA0, 1'b1);
    send_bit(0); send_bit(1); send_bit(1);
    rst_n = 0; tick(2);
    check("t6_rst_data", data_out, 0);
    check("t6_rst_flags", {is_addr, rw, ack, addr_match, valid, detected, start_pulse, stop_pulse, busy, frame_err}, 0);
    rst_n = 1; tick(2);
    snap();
    for (int i = 0; i < 5; i++) send_bit(1'(i & 1));
    send_bit(0);
    send_byte(8'h3C, 1'b1);
    check("t6_no_valid", {n_valid - b_v, n_det - b_d}, 64'd0);
    check("t6_idle_busy", busy, 0);
    bus_stop(); tick(H);
    snap();
    frame_a0_3c();
    check("t6_fresh_valid", n_valid - b_v, 2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
